// File: rtl/spi_target_if.sv
// Bus and host-side signals of the SPI target, bundled for connection between
// the core-side driver (master) and the target transceiver (slave).
interface spi_target_if;
  logic       spi_sck;
  logic       spi_ss_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       spi_enable;
  logic       cpol;
  logic       cpha;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       spi_done;

  modport master (
    output spi_sck, spi_ss_n, spi_mosi, spi_enable, cpol, cpha, tx_data, tx_wr,
    input  spi_miso, spi_miso_oe, tx_full, tx_underrun, rx_data, spi_done
  );

  modport slave (
    input  spi_sck, spi_ss_n, spi_mosi, spi_enable, cpol, cpha, tx_data, tx_wr,
    output spi_miso, spi_miso_oe, tx_full, tx_underrun, rx_data, spi_done
  );
endinterface

// File: rtl/spi_target.sv
// SPI target transceiver: oversamples SCK/SS_n/MOSI in sys_clk, all four
// CPOL/CPHA modes, 8-bit MSB-first, one TX holding buffer and one RX register.
module spi_target (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  spi_target_if.slave   bus
);

  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       ss_s1_q, ss_s2_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic       sel_q;

  logic [2:0] bcnt_q, bcnt_d;
  logic [6:0] rx_sr_q, rx_sr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic       underrun_q, underrun_d;

  logic selected;
  logic sck_edge;
  logic sample_lvl;
  logic sample_edge;
  logic shift_edge;
  logic sel_start;
  logic load;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      sck_s1_q  <= bus.spi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      ss_s1_q   <= bus.spi_ss_n;
      ss_s2_q   <= ss_s1_q;
      mosi_s1_q <= bus.spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      sel_q     <= selected;
    end
  end

  // sel_q is the delayed copy of the synchronised select; its rising edge is
  // the byte start that pre-loads tx_sr in cpha=0.
  assign selected    = ~ss_s2_q & bus.spi_enable;
  assign sck_edge    = sck_s2_q ^ sck_s3_q;
  assign sample_lvl  = ~(bus.cpol ^ bus.cpha);
  assign sample_edge = selected & sck_edge & (sck_s2_q == sample_lvl);
  assign shift_edge  = selected & sck_edge & (sck_s2_q != sample_lvl);
  assign sel_start   = selected & ~sel_q;
  assign load        = (sel_start & ~bus.cpha) | (shift_edge & (bcnt_q == 3'd0));

  always_comb begin
    bcnt_d     = bcnt_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    tx_sr_d    = tx_sr_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    underrun_d = underrun_q;

    if (!selected) begin
      bcnt_d  = 3'd0;
      rx_sr_d = 7'd0;
      tx_sr_d = 8'hFF;
    end else begin
      if (sample_edge) begin
        rx_sr_d = {rx_sr_q[5:0], mosi_s2_q};
        bcnt_d  = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
          rx_data_d = {rx_sr_q, mosi_s2_q};
          done_d    = 1'b1;
        end
      end
      if (load) begin
        if (tx_full_q) begin
          tx_sr_d   = tx_buf_q;
          tx_full_d = 1'b0;
        end else begin
          tx_sr_d    = 8'hFF;
          underrun_d = 1'b1;
        end
      end else if (shift_edge) begin
        tx_sr_d = {tx_sr_q[6:0], 1'b1};
      end
    end

    // A write lands after any same-cycle load, so it sees the freed buffer.
    if (bus.tx_wr) begin
      underrun_d = 1'b0;
      if (!tx_full_d) begin
        tx_buf_d  = bus.tx_data;
        tx_full_d = 1'b1;
      end
    end

    if (!bus.spi_enable) begin
      tx_full_d  = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bcnt_q     <= 3'd0;
      rx_sr_q    <= 7'd0;
      rx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      tx_sr_q    <= 8'hFF;
      tx_buf_q   <= 8'h00;
      tx_full_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      tx_sr_q    <= tx_sr_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.spi_miso    = tx_sr_q[7];
  assign bus.spi_miso_oe = selected;
  assign bus.tx_full     = tx_full_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.spi_done    = done_q;

endmodule
